// File: rtl/clock_mode_controller_pkg.sv
// Shared types and constants (package clock_pkg) for the alarm-clock mode controller.
// The SNOOZE_EN macro adds the SNOOZE alarm state.
package clock_pkg;

  typedef enum logic [2:0] {
    MODE_RUN,
    MODE_ADJ_CLK_HR,
    MODE_ADJ_CLK_MIN,
    MODE_ADJ_ALM_HR,
    MODE_ADJ_ALM_MIN
  } mode_e;

`ifdef SNOOZE_EN
  typedef enum logic [1:0] {
    ALM_IDLE,
    ALM_RINGING,
    ALM_SNOOZE
  } alarm_e;
`else
  typedef enum logic [0:0] {
    ALM_IDLE,
    ALM_RINGING
  } alarm_e;
`endif

  // Packed time layout: {hours_tenth[1:0], hours_units[3:0], minutes_tenth[2:0], minutes_units[3:0]}
  localparam int TIME_W    = 13;
  localparam int MIN_U_LSB = 0;
  localparam int MIN_T_LSB = 4;
  localparam int HR_U_LSB  = 7;
  localparam int HR_T_LSB  = 11;

  localparam int SEL_CLK_HR  = 0;
  localparam int SEL_CLK_MIN = 1;
  localparam int SEL_ALM_HR  = 2;
  localparam int SEL_ALM_MIN = 3;

  function automatic mode_e mode_next(mode_e m);
    case (m)
      MODE_ADJ_CLK_HR:  return MODE_ADJ_CLK_MIN;
      MODE_ADJ_CLK_MIN: return MODE_ADJ_ALM_HR;
      MODE_ADJ_ALM_HR:  return MODE_ADJ_ALM_MIN;
      default:          return MODE_ADJ_CLK_HR;
    endcase
  endfunction

  function automatic mode_e mode_prev(mode_e m);
    case (m)
      MODE_ADJ_CLK_MIN: return MODE_ADJ_CLK_HR;
      MODE_ADJ_ALM_HR:  return MODE_ADJ_CLK_MIN;
      MODE_ADJ_ALM_MIN: return MODE_ADJ_ALM_HR;
      default:          return MODE_ADJ_ALM_MIN;
    endcase
  endfunction

  // One-hot field select; also selects which adjust enable fires.
  function automatic logic [3:0] sel_onehot(mode_e m);
    logic [3:0] s;
    s = '0;
    case (m)
      MODE_ADJ_CLK_HR:  s[SEL_CLK_HR]  = 1'b1;
      MODE_ADJ_CLK_MIN: s[SEL_CLK_MIN] = 1'b1;
      MODE_ADJ_ALM_HR:  s[SEL_ALM_HR]  = 1'b1;
      MODE_ADJ_ALM_MIN: s[SEL_ALM_MIN] = 1'b1;
      default:          s = '0;
    endcase
    return s;
  endfunction

  function automatic logic [TIME_W-1:0] pack_time(logic [1:0] hr_t, logic [3:0] hr_u,
                                                  logic [2:0] min_t, logic [3:0] min_u);
    logic [TIME_W-1:0] t;
    t = '0;
    t[HR_T_LSB  +: 2] = hr_t;
    t[HR_U_LSB  +: 4] = hr_u;
    t[MIN_T_LSB +: 3] = min_t;
    t[MIN_U_LSB +: 4] = min_u;
    return t;
  endfunction

endpackage

// File: rtl/clock_mode_controller_if.sv
// Button/tick/time inputs and adjust/display/ring outputs of the mode controller.
// master drives the inputs (test or board glue); slave is the controller.
interface clock_mode_controller_if;
  import clock_pkg::*;

  logic              btn_c, btn_l, btn_r, btn_u, btn_d;
  logic              tick_1hz;
  logic              alarm_on;
  logic              sec_zero;
  logic [TIME_W-1:0] clk_time;
  logic [TIME_W-1:0] alm_time;

  logic              clk_adj_en_hr, clk_adj_en_min;
  logic              alm_adj_en_hr, alm_adj_en_min;
  logic              Up_down;
  logic              clock_run_en;
  logic [3:0]        sel_led;
  logic              blink;
  logic              ring;

  modport master (
    output btn_c, btn_l, btn_r, btn_u, btn_d, tick_1hz, alarm_on, sec_zero, clk_time, alm_time,
    input  clk_adj_en_hr, clk_adj_en_min, alm_adj_en_hr, alm_adj_en_min,
           Up_down, clock_run_en, sel_led, blink, ring
  );

  modport slave (
    input  btn_c, btn_l, btn_r, btn_u, btn_d, tick_1hz, alarm_on, sec_zero, clk_time, alm_time,
    output clk_adj_en_hr, clk_adj_en_min, alm_adj_en_hr, alm_adj_en_min,
           Up_down, clock_run_en, sel_led, blink, ring
  );

endinterface

// File: rtl/clock_mode_controller_alarm_ring_fsm.sv
// Alarm ringing FSM with shared seconds timer and time compare.
// SNOOZE_EN adds a SNOOZE state entered by btn_u while ringing.
module alarm_ring_fsm
  import clock_pkg::*;
#(
  parameter int RING_SECONDS   = 60,
  parameter int SNOOZE_SECONDS = 300,
  parameter int CNT_W          = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_mode_run,
  input  logic              i_tick_1hz,
  input  logic              i_alarm_on,
  input  logic              i_sec_zero,
  input  logic [TIME_W-1:0] i_clk_time,
  input  logic [TIME_W-1:0] i_alm_time,
  input  logic              i_btn_c,
  input  logic              i_btn_l,
  input  logic              i_btn_r,
  input  logic              i_btn_u,
  input  logic              i_btn_d,
  output logic              o_ring,
  output logic              o_btn_consumed
);

  if (((RING_SECONDS > SNOOZE_SECONDS) ? RING_SECONDS : SNOOZE_SECONDS) > (1 << CNT_W))
  begin : g_cnt_w_too_small
    $error("CNT_W cannot hold RING_SECONDS/SNOOZE_SECONDS");
  end

  localparam logic [CNT_W-1:0] RING_LAST = CNT_W'(RING_SECONDS - 1);
`ifdef SNOOZE_EN
  localparam logic [CNT_W-1:0] SNOOZE_LAST = CNT_W'(SNOOZE_SECONDS - 1);
  logic w_snooze_req;
`endif

  alarm_e           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_timer, w_timer_nxt, w_timer_inc;
  logic             r_ring;
  logic             w_any_btn, w_match;

  assign w_any_btn   = i_btn_c | i_btn_l | i_btn_r | i_btn_u | i_btn_d;
  assign w_timer_inc = r_timer + CNT_W'(1);
  // A button in the trigger cycle would dismiss at once, so it suppresses the trigger.
  assign w_match = i_tick_1hz & i_mode_run & i_alarm_on & i_sec_zero &
                   (i_clk_time == i_alm_time) & ~w_any_btn;
  assign o_btn_consumed = (r_state != ALM_IDLE) & w_any_btn;
`ifdef SNOOZE_EN
  assign w_snooze_req = i_btn_u & ~(i_btn_c | i_btn_l | i_btn_r | i_btn_d);
`endif

  // NOTE: defaults first so every path assigns every signal; no latches.
  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    if (!i_alarm_on) begin
      w_state_nxt = ALM_IDLE;
    end else begin
      case (r_state)
        ALM_IDLE: begin
          if (w_match) begin
            w_state_nxt = ALM_RINGING;
            w_timer_nxt = '0;
          end
        end
        ALM_RINGING: begin
          if (w_any_btn) begin
`ifdef SNOOZE_EN
            if (w_snooze_req) begin
              w_state_nxt = ALM_SNOOZE;
              w_timer_nxt = '0;
            end else begin
              w_state_nxt = ALM_IDLE;
            end
`else
            w_state_nxt = ALM_IDLE;
`endif
          end else if (i_tick_1hz) begin
            if (r_timer == RING_LAST) w_state_nxt = ALM_IDLE;
            else                      w_timer_nxt = w_timer_inc;
          end
        end
`ifdef SNOOZE_EN
        ALM_SNOOZE: begin
          if (w_any_btn) begin
            w_state_nxt = ALM_IDLE;
          end else if (i_tick_1hz) begin
            if (r_timer == SNOOZE_LAST) begin
              w_state_nxt = ALM_RINGING;
              w_timer_nxt = '0;
            end else begin
              w_timer_nxt = w_timer_inc;
            end
          end
        end
`endif
        default: w_state_nxt = ALM_IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ALM_IDLE;
      r_timer <= '0;
      r_ring  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
      r_ring  <= (w_state_nxt == ALM_RINGING);
    end
  end

  assign o_ring = r_ring;

endmodule

// File: rtl/clock_mode_controller.sv
// Alarm-clock UI sequencer: mode FSM, adjust pulses, display select/blink, alarm ringing.
// Define SNOOZE_EN to enable the snooze feature in the alarm FSM.
module clock_mode_controller
  import clock_pkg::*;
#(
  parameter int RING_SECONDS   = 60,
  parameter int SNOOZE_SECONDS = 300,
  parameter int CNT_W          = 9
) (
  input logic                     clk,
  input logic                     rst,
  clock_mode_controller_if.slave  bus
);

  mode_e      r_mode, w_mode_nxt;
  logic [3:0] r_adj_en, w_adj_en_nxt;
  logic       r_up_down, w_up_down_nxt;
  logic       r_run_en;
  logic [3:0] r_sel;
  logic       r_blink, w_blink_nxt;
  logic       w_btn_consumed;
  logic       w_ring;

  alarm_ring_fsm #(
    .RING_SECONDS   (RING_SECONDS),
    .SNOOZE_SECONDS (SNOOZE_SECONDS),
    .CNT_W          (CNT_W)
  ) u_alarm (
    .clk            (clk),
    .rst            (rst),
    .i_mode_run     (r_mode == MODE_RUN),
    .i_tick_1hz     (bus.tick_1hz),
    .i_alarm_on     (bus.alarm_on),
    .i_sec_zero     (bus.sec_zero),
    .i_clk_time     (bus.clk_time),
    .i_alm_time     (bus.alm_time),
    .i_btn_c        (bus.btn_c),
    .i_btn_l        (bus.btn_l),
    .i_btn_r        (bus.btn_r),
    .i_btn_u        (bus.btn_u),
    .i_btn_d        (bus.btn_d),
    .o_ring         (w_ring),
    .o_btn_consumed (w_btn_consumed)
  );

  // Navigation outranks direction buttons; a button that silenced the alarm is dropped.
  always_comb begin
    w_mode_nxt    = r_mode;
    w_adj_en_nxt  = '0;
    w_up_down_nxt = r_up_down;
    if (!w_btn_consumed) begin
      if (r_mode == MODE_RUN) begin
        if (bus.btn_c) w_mode_nxt = MODE_ADJ_CLK_HR;
      end else if (bus.btn_c) begin
        w_mode_nxt = MODE_RUN;
      end else if (bus.btn_r) begin
        w_mode_nxt = mode_next(r_mode);
      end else if (bus.btn_l) begin
        w_mode_nxt = mode_prev(r_mode);
      end else if (bus.btn_u ^ bus.btn_d) begin
        w_adj_en_nxt  = sel_onehot(r_mode);
        w_up_down_nxt = bus.btn_u;
      end
    end
  end

  always_comb begin
    w_blink_nxt = r_blink;
    if ((w_mode_nxt != r_mode) || (w_mode_nxt == MODE_RUN)) w_blink_nxt = 1'b0;
    else if (bus.tick_1hz)                                  w_blink_nxt = ~r_blink;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode    <= MODE_RUN;
      r_adj_en  <= '0;
      r_up_down <= 1'b0;
      r_run_en  <= 1'b1;
      r_sel     <= '0;
      r_blink   <= 1'b0;
    end else begin
      r_mode    <= w_mode_nxt;
      r_adj_en  <= w_adj_en_nxt;
      r_up_down <= w_up_down_nxt;
      r_run_en  <= (w_mode_nxt == MODE_RUN);
      r_sel     <= sel_onehot(w_mode_nxt);
      r_blink   <= w_blink_nxt;
    end
  end

  assign bus.clk_adj_en_hr  = r_adj_en[SEL_CLK_HR];
  assign bus.clk_adj_en_min = r_adj_en[SEL_CLK_MIN];
  assign bus.alm_adj_en_hr  = r_adj_en[SEL_ALM_HR];
  assign bus.alm_adj_en_min = r_adj_en[SEL_ALM_MIN];
  assign bus.Up_down        = r_up_down;
  assign bus.clock_run_en   = r_run_en;
  assign bus.sel_led        = r_sel;
  assign bus.blink          = r_blink;
  assign bus.ring           = w_ring;

endmodule

// File: tb/tb_clock_mode_controller.sv
// Self-checking bench for clock_mode_controller: vector table, alarm sequences,
// then random stimulus against a behavioural model. Honours SNOOZE_EN.
module tb_clock_mode_controller;
  import clock_pkg::*;

  localparam int RING   = 60;
  localparam int SNOOZE = 300;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  clock_mode_controller_if bus ();

  clock_mode_controller #(
    .RING_SECONDS   (RING),
    .SNOOZE_SECONDS (SNOOZE),
    .CNT_W          (9)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Model state: mode 0=RUN, 1..4 = CLK_HR, CLK_MIN, ALM_HR, ALM_MIN; alarm 0 idle, 1 ringing, 2 snooze.
  int          m_mode, m_alarm, m_cnt;
  bit          m_ud, m_blink;
  logic [11:0] m_out;

  typedef struct {
    string      name;
    logic [4:0] btn;   // {c, l, r, u, d}
    logic       tick;
    logic [3:0] en;    // same bit order as sel_led
    logic       ud;
    logic       run;
    logic [3:0] sel;
    logic       blink;
  } vec_t;

  localparam logic [4:0] B_C = 5'b10000, B_L = 5'b01000, B_R = 5'b00100,
                         B_U = 5'b00010, B_D = 5'b00001, B_0 = 5'b00000;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  function automatic logic [11:0] dut_out();
    return {bus.alm_adj_en_min, bus.alm_adj_en_hr, bus.clk_adj_en_min, bus.clk_adj_en_hr,
            bus.Up_down, bus.clock_run_en, bus.sel_led, bus.blink, bus.ring};
  endfunction

  task automatic model_step();
    bit c, l, r, u, d, tick, any_btn, consumed;
    int nm;
    logic [3:0] en, sel;
    c = bus.btn_c; l = bus.btn_l; r = bus.btn_r; u = bus.btn_u; d = bus.btn_d;
    tick = bus.tick_1hz;
    en = '0;
    if (rst) begin
      m_mode = 0; m_alarm = 0; m_cnt = 0; m_ud = 0; m_blink = 0;
    end else begin
      any_btn  = c | l | r | u | d;
      consumed = any_btn && (m_alarm != 0);
      nm = m_mode;
      if (!consumed) begin
        if (m_mode == 0) begin
          if (c) nm = 1;
        end else if (c) nm = 0;
        else if (r) nm = m_mode % 4 + 1;
        else if (l) nm = (m_mode + 2) % 4 + 1;
        else if (u != d) begin
          en   = 4'(1 << (m_mode - 1));
          m_ud = u;
        end
      end
      if (!bus.alarm_on) m_alarm = 0;
      else if (m_alarm == 1) begin
        if (any_btn) begin
`ifdef SNOOZE_EN
          if (u && !c && !l && !r && !d) begin m_alarm = 2; m_cnt = 0; end
          else m_alarm = 0;
`else
          m_alarm = 0;
`endif
        end else if (tick) begin
          m_cnt++;
          if (m_cnt == RING) m_alarm = 0;
        end
      end else if (m_alarm == 2) begin
        if (any_btn) m_alarm = 0;
        else if (tick) begin
          m_cnt++;
          if (m_cnt == SNOOZE) begin m_alarm = 1; m_cnt = 0; end
        end
      end else if (tick && m_mode == 0 && bus.sec_zero && bus.clk_time == bus.alm_time && !any_btn) begin
        m_alarm = 1; m_cnt = 0;
      end
      if (nm != m_mode || nm == 0) m_blink = 0;
      else if (tick) m_blink = !m_blink;
      m_mode = nm;
    end
    sel = (m_mode == 0) ? 4'b0000 : 4'(1 << (m_mode - 1));
    m_out = {en, m_ud, m_mode == 0, sel, m_blink, m_alarm == 1};
  endtask

  // Applies one cycle of stimulus, advances the model, compares all outputs.
  task automatic step(input logic [4:0] btn, input logic tick, input logic rst_v);
    {bus.btn_c, bus.btn_l, bus.btn_r, bus.btn_u, bus.btn_d} = btn;
    bus.tick_1hz = tick;
    rst = rst_v;
    model_step();
    @(posedge clk);
    #1;
    {bus.btn_c, bus.btn_l, bus.btn_r, bus.btn_u, bus.btn_d} = '0;
    bus.tick_1hz = 1'b0;
    rst = 1'b0;
    check("model", 32'(dut_out()), 32'(m_out));
  endtask

  task automatic trigger_alarm();
    bus.sec_zero = 1'b1;
    step(B_0, 1'b1, 1'b0);
    bus.sec_zero = 1'b0;
  endtask

  vec_t vecs[$];
  logic [TIME_W-1:0] t_a, t_b;

  initial begin
    {bus.btn_c, bus.btn_l, bus.btn_r, bus.btn_u, bus.btn_d} = '0;
    bus.tick_1hz = 1'b0;
    bus.alarm_on = 1'b0;
    bus.sec_zero = 1'b0;
    t_a = pack_time(2'd0, 4'd7, 3'd3, 4'd0);
    t_b = pack_time(2'd1, 4'd2, 3'd5, 4'd9);
    bus.clk_time = t_a;
    bus.alm_time = t_a;

    step(B_0, 1'b0, 1'b1);
    check("reset_state", 32'(dut_out()), 32'h040);

    vecs = '{
      '{"enter_adj",     B_C,       1'b0, 4'b0000, 1'b0, 1'b0, 4'b0001, 1'b0},
      '{"clk_hr_up",     B_U,       1'b0, 4'b0001, 1'b1, 1'b0, 4'b0001, 1'b0},
      '{"ud_hold",       B_0,       1'b0, 4'b0000, 1'b1, 1'b0, 4'b0001, 1'b0},
      '{"blink_on",      B_0,       1'b1, 4'b0000, 1'b1, 1'b0, 4'b0001, 1'b1},
      '{"nav_r_min",     B_R,       1'b0, 4'b0000, 1'b1, 1'b0, 4'b0010, 1'b0},
      '{"clk_min_dn",    B_D,       1'b0, 4'b0010, 1'b0, 1'b0, 4'b0010, 1'b0},
      '{"u_and_d",       B_U | B_D, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0010, 1'b0},
      '{"u_with_r",      B_U | B_R, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0100, 1'b0},
      '{"nav_r_almmin",  B_R,       1'b0, 4'b0000, 1'b0, 1'b0, 4'b1000, 1'b0},
      '{"alm_min_up",    B_U,       1'b0, 4'b1000, 1'b1, 1'b0, 4'b1000, 1'b0},
      '{"wrap_r",        B_R,       1'b0, 4'b0000, 1'b1, 1'b0, 4'b0001, 1'b0},
      '{"wrap_l",        B_L,       1'b0, 4'b0000, 1'b1, 1'b0, 4'b1000, 1'b0},
      '{"nav_l",         B_L,       1'b0, 4'b0000, 1'b1, 1'b0, 4'b0100, 1'b0},
      '{"alm_hr_dn",     B_D,       1'b0, 4'b0100, 1'b0, 1'b0, 4'b0100, 1'b0},
      '{"blink_1",       B_0,       1'b1, 4'b0000, 1'b0, 1'b0, 4'b0100, 1'b1},
      '{"blink_0",       B_0,       1'b1, 4'b0000, 1'b0, 1'b0, 4'b0100, 1'b0},
      '{"blink_1b",      B_0,       1'b1, 4'b0000, 1'b0, 1'b0, 4'b0100, 1'b1},
      '{"tick_with_nav", B_R,       1'b1, 4'b0000, 1'b0, 1'b0, 4'b1000, 1'b0},
      '{"exit_run",      B_C,       1'b0, 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0},
      '{"run_ignores_u", B_U,       1'b0, 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0},
      '{"run_ignores_r", B_R,       1'b0, 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0},
      '{"run_no_blink",  B_0,       1'b1, 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0},
      '{"d_with_c",      B_C | B_D, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0001, 1'b0},
      '{"back_to_run",   B_C,       1'b0, 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0}
    };
    foreach (vecs[i]) begin
      step(vecs[i].btn, vecs[i].tick, 1'b0);
      check(vecs[i].name, 32'(dut_out()),
            32'({vecs[i].en, vecs[i].ud, vecs[i].run, vecs[i].sel, vecs[i].blink, 1'b0}));
    end

    // Alarm rings on match and auto-silences after RING further ticks.
    bus.alarm_on = 1'b1;
    trigger_alarm();
    check("ring_start", 32'(bus.ring), 32'd1);
    for (int i = 1; i < RING; i++) step(B_0, 1'b1, 1'b0);
    check("ring_before_timeout", 32'(bus.ring), 32'd1);
    step(B_0, 1'b1, 1'b0);
    check("ring_timeout", 32'(bus.ring), 32'd0);

    // btn_c silences and is consumed: still RUN, no field selected.
    trigger_alarm();
    check("ring_again", 32'(bus.ring), 32'd1);
    step(B_C, 1'b0, 1'b0);
    check("dismiss_consumed", 32'(dut_out()), 32'h040);

    trigger_alarm();
    bus.alarm_on = 1'b0;
    step(B_0, 1'b0, 1'b0);
    check("alarm_off_silences", 32'(bus.ring), 32'd0);
    bus.alarm_on = 1'b1;

    // Match while adjusting the alarm hour must not ring.
    step(B_C, 1'b0, 1'b0);
    step(B_R, 1'b0, 1'b0);
    step(B_R, 1'b0, 1'b0);
    step(B_U, 1'b0, 1'b0);
    trigger_alarm();
    check("no_ring_in_adj", 32'(bus.ring), 32'd0);
    check("adj_alm_hr_sel", 32'(bus.sel_led), 32'b0100);
    step(B_C, 1'b0, 1'b0);

    // Reset while ringing (Up_down is 1 here) restores every output.
    trigger_alarm();
    check("ring_before_rst", 32'(bus.ring), 32'd1);
    step(B_0, 1'b0, 1'b1);
    check("rst_mid_ring", 32'(dut_out()), 32'h040);

    trigger_alarm();
    step(B_U, 1'b0, 1'b0);
    check("btn_u_silences", 32'(bus.ring), 32'd0);
    for (int i = 1; i < SNOOZE; i++) step(B_0, 1'b1, 1'b0);
    check("quiet_before_snooze_end", 32'(bus.ring), 32'd0);
    step(B_0, 1'b1, 1'b0);
`ifdef SNOOZE_EN
    check("snooze_rering", 32'(bus.ring), 32'd1);
    step(B_L, 1'b0, 1'b0);
    check("snooze_dismiss_l", 32'({bus.ring, bus.sel_led}), 32'd0);
    step(B_0, 1'b1, 1'b0);
    check("idle_after_dismiss", 32'(bus.ring), 32'd0);
`else
    check("no_snooze_return", 32'(bus.ring), 32'd0);
`endif

    // Random traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      logic [4:0] btn;
      for (int b = 0; b < 5; b++) btn[b] = ($urandom_range(9) == 0);
      bus.alarm_on = ($urandom_range(15) != 0);
      bus.sec_zero = $urandom_range(1);
      bus.clk_time = $urandom_range(1) ? t_a : t_b;
      bus.alm_time = $urandom_range(1) ? t_a : t_b;
      step(btn, ($urandom_range(2) == 0), ($urandom_range(499) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/clock_mode_controller.md
Name: clock_mode_controller

Overview:
- Top-level user-interface sequencer for the Basys 3 alarm clock.
- Consumes debounced single-cycle button pulses, the 1 Hz tick, the current clock time and the alarm time.
- Generates the adjust-enable and Up_down controls for the clock-time and alarm-time counters, gates the running clock, and owns the alarm ringing FSM.

Parameters:
- RING_SECONDS, 60: ticks the alarm rings before auto-silencing.
- SNOOZE_SECONDS, 300: ticks spent in snooze before ringing again (used only with SNOOZE_EN).
- CNT_W, 9: width of the shared seconds timer; must hold max(RING_SECONDS, SNOOZE_SECONDS).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- btn_c, btn_l, btn_r, btn_u, btn_d  in  1 each  debounced one-cycle pulses
- tick_1hz  in  1  one-cycle pulse per second
- alarm_on  in  1  alarm enable switch
- sec_zero  in  1  clock seconds == 00
- clk_time  in  13  {hours_tenth[1:0], hours_units[3:0], minutes_tenth[2:0], minutes_units[3:0]}
- alm_time  in  13  same packing as clk_time
- clk_adj_en_hr, clk_adj_en_min  out  1  one-cycle enables to the clock counters
- alm_adj_en_hr, alm_adj_en_min  out  1  one-cycle enables to the alarm counters
- Up_down  out  1  count direction: 1 = up
- clock_run_en  out  1  clock advances only when 1
- sel_led  out  4  one-hot field select, [0]=clk hr, [1]=clk min, [2]=alm hr, [3]=alm min
- blink  out  1  display blink phase for the selected field
- ring  out  1  buzzer/LED drive

Behaviour:
- All outputs registered.
- Reset values: all enables 0, Up_down 0, clock_run_en 1, sel_led 0, blink 0, ring 0. Mode FSM resets to RUN; alarm FSM resets to IDLE; timer resets to 0.
- Mode FSM states: RUN, ADJ_CLK_HR, ADJ_CLK_MIN, ADJ_ALM_HR, ADJ_ALM_MIN.
  - RUN + btn_c -> ADJ_CLK_HR.
  - Any ADJ state + btn_c -> RUN.
  - btn_r moves to the next ADJ state in the listed order; ADJ_ALM_MIN wraps to ADJ_CLK_HR. btn_l moves to the previous state, wrapping the other way.
  - btn_l, btn_r, btn_u and btn_d are ignored in RUN.
- Adjust pulses:
  - In an ADJ state, btn_u (btn_d) at cycle N drives exactly the matching enable high at N+1 for one cycle, with Up_down=1 (0) in that same cycle.
  - Up_down holds its last value otherwise.
  - btn_u and btn_d in the same cycle: no pulse.
  - A direction button together with btn_l/btn_r/btn_c: the navigation button wins and no pulse is issued.
- clock_run_en = 1 only in RUN; it updates the cycle after the state change.
- sel_led is one-hot in the ADJ states and 0 in RUN.
- blink toggles on each tick_1hz while in an ADJ state; it is forced to 0 on entry to RUN and on any state change.
- Alarm FSM states: IDLE, RINGING (plus SNOOZE, see Optional Feature).
  - IDLE -> RINGING on a tick_1hz cycle when all hold: mode==RUN, alarm_on, sec_zero, clk_time==alm_time. Timer cleared on entry.
  - RINGING: ring=1. The timer counts tick_1hz.
  - RINGING -> IDLE when the timer reaches RING_SECONDS, when alarm_on=0, or on any button pulse.
  - A button pulse that silences the alarm is consumed: it does not affect the mode FSM in that cycle.
  - alarm_on=0 forces IDLE from any alarm state within one cycle.
  - A match cannot re-trigger in the same minute, because sec_zero is only true for one second and ringing covers it.
  - Mode is always RUN while ringing, since triggering requires RUN and buttons are consumed.
- rst asserted mid-ring or mid-adjust: the next edge returns all state and outputs to their reset values.

Optional Feature:
- Macro: SNOOZE_EN.
- Defined:
  - btn_u in RINGING -> SNOOZE: ring=0, timer cleared.
  - SNOOZE -> RINGING after SNOOZE_SECONDS ticks, with the timer cleared again.
  - Any other button in RINGING or SNOOZE -> IDLE.
  - alarm_on=0 -> IDLE.
  - Unlimited snoozes.
- Undefined: the SNOOZE state is absent and btn_u dismisses like any other button. SNOOZE_SECONDS is unused.

Decomposition:
- Shared package clock_pkg holds:
  - mode and alarm state encodings;
  - the 13-bit time packing field offsets;
  - sel_led bit indices.
- Natural sub-module: alarm_ring_fsm. It contains the alarm FSM, the seconds timer and the compare logic. Its inputs are mode==RUN, the time buses, tick_1hz, alarm_on, sec_zero and the button pulses; its outputs are ring and a button-consumed flag.

Test Plan:
- rst, then btn_c -> next cycle sel_led=0001, clock_run_en=0. Three btn_r pulses -> sel_led=1000. One more btn_r -> 0001 (wrap).
- ADJ_CLK_MIN, btn_d at cycle N -> clk_adj_en_min=1 and Up_down=0 at N+1 only, all other enables 0. btn_u+btn_d together -> no pulse.
- RUN, alarm_on=1, clk_time=alm_time=07:30, sec_zero=1, tick_1hz -> ring=1 next cycle. 60 further ticks -> ring=0.
- Ringing, btn_c -> ring=0, mode stays RUN, sel_led stays 0000. Ringing, alarm_on dropped -> ring=0 next cycle.
- Match conditions while in ADJ_ALM_HR -> ring stays 0. Assert rst while ringing -> ring=0 and all outputs at reset values.
- SNOOZE_EN defined, ringing, btn_u -> ring=0. After 300 ticks -> ring=1. btn_l -> ring=0, state IDLE.
